// File: rtl/dac_scale_sequencer_if.sv
// Valid/ready stream bundle shared by the scale-sequencer ports.
//   valid : source has a beat on data
//   ready : sink accepts the beat this cycle
//   data  : beat payload, WIDTH bits
// master drives valid/data, slave drives ready.
interface dac_scale_sequencer_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dac_scale_sequencer.sv
// Owns the prescaler's scale factor. A new scale factor is applied only after
// every beat already inside the prescaler has come out. Input data is held off
// while the change is in progress, so no output beat mixes two scale factors.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   scale_in       : requested scale factor (slave stream)
//   data_in        : upstream sample beats (slave stream)
//   data_out       : beats to the prescaler (master stream)
//   scale_out      : current scale factor to the prescaler, valid always high
//   pre_out_valid  : prescaler output valid (monitor)
//   pre_out_ready  : prescaler output ready (monitor)
//   busy           : high while a scale change is in progress
//   overflow       : sticky, the in-flight count tried to exceed MAX_IN_FLIGHT
module dac_scale_sequencer #(
    parameter int unsigned SAMPLE_WIDTH     = 16,
    parameter int unsigned PARALLEL_SAMPLES = 16,
    parameter int unsigned SCALE_WIDTH      = 18,
    parameter int unsigned SCALE_FRAC_BITS  = 16,
    parameter int unsigned MAX_IN_FLIGHT    = 8,
    parameter int unsigned SETTLE_CYCLES    = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    dac_scale_sequencer_if.slave         scale_in,
    dac_scale_sequencer_if.slave         data_in,
    dac_scale_sequencer_if.master        data_out,
    dac_scale_sequencer_if.master        scale_out,
    input  logic                         pre_out_valid,
    input  logic                         pre_out_ready,
    output logic                         busy,
    output logic                         overflow
);
    localparam int unsigned DATA_W   = SAMPLE_WIDTH * PARALLEL_SAMPLES;
    localparam int unsigned CNT_W    = $clog2(MAX_IN_FLIGHT + 1);
    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [SCALE_WIDTH-1:0] SCALE_ONE   = SCALE_WIDTH'(1) << SCALE_FRAC_BITS;
    localparam logic [CNT_W-1:0]       CNT_MAX     = CNT_W'(MAX_IN_FLIGHT);
    localparam logic [SETTLE_W-1:0]    SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? SETTLE_W'(SETTLE_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_UPDATE,
        ST_SETTLE
    } state_e;

    state_e                  state_q, state_d;
    logic [SCALE_WIDTH-1:0]  scale_q, scale_d;
    logic [CNT_W-1:0]        in_flight_q, in_flight_d;
    logic [SETTLE_W-1:0]     settle_q, settle_d;
    logic                    overflow_q, overflow_d;

    logic                    run_c;
    logic                    inc_c;
    logic                    dec_c;
    logic                    unused_scale_ready;

    // The prescaler always takes scale_factor, so its ready carries no information.
    assign unused_scale_ready = scale_out.ready;

    assign run_c = (state_q == ST_RUN);
    assign inc_c = run_c && data_in.valid && data_out.ready;
    assign dec_c = pre_out_valid && pre_out_ready;

    // Data path is a straight wire; only the handshake is gated.
    assign data_out.data  = DATA_W'(data_in.data);
    assign data_out.valid = run_c && data_in.valid;
    assign data_in.ready  = run_c && data_out.ready;

    assign scale_in.ready  = (state_q == ST_UPDATE);
    assign scale_out.valid = 1'b1;
    assign scale_out.data  = scale_q;

    assign busy     = !run_c;
    assign overflow = overflow_q;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            scale_q     <= SCALE_ONE;
            in_flight_q <= '0;
            settle_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            scale_q     <= scale_d;
            in_flight_q <= in_flight_d;
            settle_q    <= settle_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state, in-flight tracking and scale update.
    always_comb begin
        state_d     = state_q;
        scale_d     = scale_q;
        in_flight_d = in_flight_q;
        settle_d    = settle_q;
        overflow_d  = overflow_q;

        // Simultaneous entry and exit leaves the count unchanged.
        if (inc_c && !dec_c) begin
            if (in_flight_q == CNT_MAX) begin
                overflow_d = 1'b1;
            end else begin
                in_flight_d = in_flight_q + CNT_W'(1);
            end
        end else if (dec_c && !inc_c && (in_flight_q != '0)) begin
            in_flight_d = in_flight_q - CNT_W'(1);
        end

        case (state_q)
            ST_RUN: begin
                if (scale_in.valid) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (in_flight_q == '0) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                // A request withdrawn before UPDATE is dropped without touching the scale.
                if (scale_in.valid) begin
                    scale_d = scale_in.data;
                    if (SETTLE_CYCLES == 0) begin
                        state_d = ST_RUN;
                    end else begin
                        settle_d = SETTLE_LOAD;
                        state_d  = ST_SETTLE;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end
endmodule

// File: tb/tb_dac_scale_sequencer.sv
// Self-checking bench for dac_scale_sequencer with a behavioural prescaler model.
module tb_dac_scale_sequencer;
    localparam int unsigned SW   = 18;
    localparam int unsigned DW   = 256;
    localparam int          MAXF = 8;
    localparam int          LAT  = 4;
    localparam logic [SW-1:0] ONE = 18'h10000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic pre_out_valid = 1'b0;
    logic pre_out_ready = 1'b0;
    logic busy;
    logic overflow;

    dac_scale_sequencer_if #(.WIDTH(SW)) sin_if  ();
    dac_scale_sequencer_if #(.WIDTH(DW)) din_if  ();
    dac_scale_sequencer_if #(.WIDTH(DW)) dout_if ();
    dac_scale_sequencer_if #(.WIDTH(SW)) sout_if ();

    dac_scale_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .scale_in      (sin_if),
        .data_in       (din_if),
        .data_out      (dout_if),
        .scale_out     (sout_if),
        .pre_out_valid (pre_out_valid),
        .pre_out_ready (pre_out_ready),
        .busy          (busy),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sv;
        logic [SW-1:0] sd;
        logic          busy;
        logic          rdy;
        logic [SW-1:0] scale;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;

    // Stimulus knobs
    bit src_en   = 1'b0;
    int src_pct  = 100;
    bit rdy_rand = 1'b0;
    bit cap_en   = 1'b1;
    bit pre_en   = 1'b1;
    int pre_mode = 1;    // 0: ready low, 1: ready high, 2: random

    // Reference model state
    logic [SW-1:0] req_q[$];
    logic [SW-1:0] pq_scale[$];
    int            pq_time[$];
    logic [DW-1:0] exp_q[$];
    logic [SW-1:0] m_scale = ONE;
    int            m_cnt = 0;
    bit            m_ovf = 1'b0;
    int            cyc = 0;
    bit            prev_busy, prev_sv, saw_run, scale_hs, src_taken;
    int            hs_count = 0;
    int            hs_since_reset = 0;
    int            n_beats = 0;
    logic          s_busy, s_ready, s_ovf;
    logic [SW-1:0] s_scale;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // One clock: drive inputs, check/advance the model at negedge, step past posedge.
    task automatic cycle();
        bit in_hs, out_hs, pre_hs;
        pre_out_valid = 1'b0;
        if (pre_en && pq_time.size() > 0) pre_out_valid = ((cyc - pq_time[0]) >= LAT);
        case (pre_mode)
            0:       pre_out_ready = 1'b0;
            1:       pre_out_ready = 1'b1;
            default: pre_out_ready = 1'($urandom_range(0, 1));
        endcase
        dout_if.ready = (!cap_en || pq_scale.size() < MAXF) && (!rdy_rand || $urandom_range(0, 3) != 0);
        if (src_en && (!din_if.valid || src_taken)) begin
            din_if.valid = ($urandom_range(0, 99) < src_pct);
            din_if.data  = rand_beat();
        end
        src_taken = 1'b0;
        if (!sin_if.valid && req_q.size() > 0) begin
            sin_if.valid = 1'b1;
            sin_if.data  = req_q.pop_front();
        end

        @(negedge clk);
        s_busy   = busy;
        s_ready  = sin_if.ready;
        s_scale  = sout_if.data;
        s_ovf    = overflow;
        scale_hs = 1'b0;
        if (reset) begin
            m_scale = ONE; m_cnt = 0; m_ovf = 1'b0;
            pq_scale.delete(); pq_time.delete(); exp_q.delete(); req_q.delete();
            sin_if.valid = 1'b0;
            if (src_en) din_if.valid = 1'b0;
            prev_busy = 1'b0; prev_sv = 1'b0; saw_run = 1'b0; hs_since_reset = 0;
        end else begin
            in_hs  = din_if.valid && din_if.ready;
            out_hs = dout_if.valid && dout_if.ready;
            pre_hs = pre_out_valid && pre_out_ready;
            chk("dout_data", dout_if.data, din_if.data);
            chk1("dout_valid", dout_if.valid, din_if.valid && !s_busy);
            chk1("din_ready", din_if.ready, dout_if.ready && !s_busy);
            chk("scale_out", DW'(s_scale), DW'(m_scale));
            chk1("scale_valid", sout_if.valid, 1'b1);
            chk1("overflow", s_ovf, m_ovf);
            chk1("xfer_match", in_hs, out_hs);
            if (s_ready) chk1("ready_busy", s_busy, 1'b1);
            if (prev_sv && !prev_busy) chk1("busy_onset", s_busy, 1'b1);
            if (sin_if.valid && s_ready) begin
                chk1("drain_empty", pq_scale.size() == 0, 1'b1);
                if (hs_since_reset > 0) chk1("run_gap", saw_run, 1'b1);
                m_scale = sin_if.data;
                saw_run = 1'b0;
                hs_count++;
                hs_since_reset++;
                scale_hs = 1'b1;
            end
            if (in_hs) exp_q.push_back(din_if.data);
            if (out_hs) begin
                if (exp_q.size() == 0) chk1("beat_dup", 1'b0, 1'b1);
                else chk("beat_order", dout_if.data, exp_q.pop_front());
                pq_scale.push_back(m_scale);
                pq_time.push_back(cyc);
                n_beats++;
            end
            if (pre_hs) begin
                chk("exit_scale", DW'(s_scale), DW'(pq_scale.pop_front()));
                void'(pq_time.pop_front());
            end
            if (out_hs && !pre_hs) begin
                if (m_cnt == MAXF) m_ovf = 1'b1;
                else m_cnt++;
            end else if (pre_hs && !out_hs && m_cnt > 0) begin
                m_cnt--;
            end
            if (!s_busy) saw_run = 1'b1;
            prev_busy = s_busy;
            prev_sv   = sin_if.valid;
            src_taken = in_hs;
        end

        @(posedge clk);
        #1;
        cyc++;
        if (scale_hs) begin
            if (req_q.size() > 0) sin_if.data = req_q.pop_front();
            else sin_if.valid = 1'b0;
        end
    endtask

    initial begin
        vec_t tbl[13];
        int   hs0;
        int   reqs;
        tbl[0]  = '{1'b1, 18'h08000, 1'b0, 1'b0, 18'h10000};
        tbl[1]  = '{1'b1, 18'h08000, 1'b1, 1'b0, 18'h10000};
        tbl[2]  = '{1'b1, 18'h08000, 1'b1, 1'b1, 18'h10000};
        tbl[3]  = '{1'b0, 18'h00000, 1'b1, 1'b0, 18'h08000};
        tbl[4]  = '{1'b0, 18'h00000, 1'b1, 1'b0, 18'h08000};
        tbl[5]  = '{1'b0, 18'h00000, 1'b1, 1'b0, 18'h08000};
        tbl[6]  = '{1'b0, 18'h00000, 1'b0, 1'b0, 18'h08000};
        tbl[7]  = '{1'b0, 18'h00000, 1'b0, 1'b0, 18'h08000};
        tbl[8]  = '{1'b1, 18'h3C000, 1'b0, 1'b0, 18'h08000};
        tbl[9]  = '{1'b0, 18'h00000, 1'b1, 1'b0, 18'h08000};
        tbl[10] = '{1'b0, 18'h00000, 1'b1, 1'b1, 18'h08000};
        tbl[11] = '{1'b0, 18'h00000, 1'b0, 1'b0, 18'h08000};
        tbl[12] = '{1'b0, 18'h00000, 1'b0, 1'b0, 18'h08000};

        sin_if.valid = 1'b0; sin_if.data = '0;
        din_if.valid = 1'b0; din_if.data = '0;
        dout_if.ready = 1'b0; sout_if.ready = 1'b1;

        // Reset values
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        chk1("rst_busy", s_busy, 1'b0);
        chk("rst_scale", DW'(s_scale), DW'(ONE));
        chk1("rst_ovf", s_ovf, 1'b0);
        chk1("rst_sready", s_ready, 1'b0);

        // Pass-through at scale 1.0
        src_en = 1'b1; src_pct = 100; n_beats = 0;
        for (int c = 0; c < 1000 && n_beats < 200; c++) begin
            cycle();
            chk1("t1_busy", s_busy, 1'b0);
        end
        chk1("t1_beats", n_beats >= 200, 1'b1);
        src_en = 1'b0; din_if.valid = 1'b0;
        for (int c = 0; c < 50 && pq_scale.size() > 0; c++) cycle();
        chk1("t1_drained", pq_scale.size() == 0, 1'b1);

        // Update with empty pipeline, then an abandoned request
        foreach (tbl[i]) begin
            sin_if.valid = tbl[i].sv;
            sin_if.data  = tbl[i].sd;
            cycle();
            chk1($sformatf("tbl%0d_busy", i), s_busy, tbl[i].busy);
            chk1($sformatf("tbl%0d_ready", i), s_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_scale", i), DW'(s_scale), DW'(tbl[i].scale));
        end

        // Update under continuous load
        src_en = 1'b1; src_pct = 100; rdy_rand = 1'b0; pre_mode = 1;
        repeat (20) cycle();
        hs0 = hs_count;
        req_q.push_back(18'h3C000);
        for (int c = 0; c < 200 && hs_count == hs0; c++) cycle();
        repeat (30) cycle();
        chk("t3_scale", DW'(s_scale), DW'(18'h3C000));

        // Random backpressure with interleaved updates
        src_pct = 70; rdy_rand = 1'b1; pre_mode = 2;
        n_beats = 0; reqs = 0; hs0 = hs_count;
        for (int c = 0; c < 20000 && (n_beats < 500 || reqs < 10); c++) begin
            if (reqs < 10 && req_q.size() == 0 && !sin_if.valid && $urandom_range(0, 39) == 0) begin
                req_q.push_back(18'($urandom()));
                reqs++;
            end
            cycle();
        end
        for (int c = 0; c < 500 && (req_q.size() > 0 || sin_if.valid || s_busy); c++) cycle();
        chk1("t4_beats", n_beats >= 500, 1'b1);
        chk("t4_updates", DW'(hs_count - hs0), DW'(10));

        // Back-to-back requests
        hs0 = hs_count;
        req_q.push_back(18'h10000);
        req_q.push_back(18'h04000);
        for (int c = 0; c < 400 && (hs_count < hs0 + 2 || s_busy); c++) cycle();
        chk("b2b_count", DW'(hs_count - hs0), DW'(2));
        chk("b2b_scale", DW'(s_scale), DW'(18'h04000));

        // Reset while draining
        pre_mode = 0; rdy_rand = 1'b0; src_pct = 100;
        repeat (4) cycle();
        req_q.push_back(18'h20000);
        for (int c = 0; c < 20 && !s_busy; c++) cycle();
        repeat (2) cycle();
        chk1("drain_busy", s_busy, 1'b1);
        chk1("drain_sready", s_ready, 1'b0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        src_en = 1'b0; din_if.valid = 1'b0; pre_mode = 1;
        cycle();
        chk("drst_scale", DW'(s_scale), DW'(ONE));
        chk1("drst_busy", s_busy, 1'b0);

        // Overflow: MAX_IN_FLIGHT beats are fine, one more sets the sticky flag
        pre_en = 1'b0; cap_en = 1'b0;
        for (int i = 0; i < MAXF; i++) begin
            din_if.valid = 1'b1; din_if.data = rand_beat();
            cycle();
        end
        din_if.valid = 1'b0;
        cycle();
        chk1("ovf_at_max", s_ovf, 1'b0);
        din_if.valid = 1'b1; din_if.data = rand_beat();
        cycle();
        din_if.valid = 1'b0;
        cycle();
        chk1("ovf_set", s_ovf, 1'b1);
        pre_en = 1'b1;
        repeat (20) cycle();
        chk1("ovf_sticky", s_ovf, 1'b1);
        chk1("ovf_drained", pq_scale.size() == 0, 1'b1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        chk1("ovf_clear", s_ovf, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
